sram_axi4_param: RTL and testbench

Parametrised AXI4 slave with an on-chip SRAM. Successor to the fixed-width 8-bit-address SRAM slave: configurable data width, address width and depth; full FIXED/INCR/WRAP burst support with byte strobes; SLVERR responses; read/write arbitration.
Serves as the memory target behind sram_axi4_m-style masters and the interconnect.

---
 rtl/sram_axi4_pkg.sv | 21 ++
 rtl/sram_axi4_addr_gen.sv | 40 ++++
 rtl/sram_axi4_param.sv | 246 ++++++++++++++++++++++++
 tb/tb_sram_axi4_param.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi4_pkg.sv
// Shared types and constants for the parametrised AXI4 SRAM slave.
package sram_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_WRESP = 2'b10,
        ST_READ  = 2'b11
    } state_e;

endpackage

// File: rtl/sram_axi4_addr_gen.sv
// Next-beat address and burst legality for FIXED/INCR/WRAP bursts.
module sram_axi4_addr_gen
    import sram_axi4_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_legal
);

    localparam int unsigned BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic [31:0]       span;

    // Wrap keeps the upper bits of the aligned block and increments only inside it.
    always_comb begin
        incr_addr   = i_addr + ADDR_W'(BYTES);
        span        = (32'(i_len) + 32'd1) * 32'(BYTES);
        wrap_mask   = ADDR_W'(span - 32'd1);
        o_next_addr = i_addr;
        o_legal     = 1'b1;
        case (burst_e'(i_burst))
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = incr_addr;
            BURST_WRAP: begin
                o_next_addr = (i_addr & ~wrap_mask) | (incr_addr & wrap_mask);
                o_legal     = (i_len == 8'd1) || (i_len == 8'd3) ||
                              (i_len == 8'd7) || (i_len == 8'd15);
            end
            default:     o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sram_axi4_param.sv
// AXI4 slave over an on-chip SRAM with round-robin read/write arbitration.
module sram_axi4_param
    import sram_axi4_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic [7:0]            i_awlen,
    input  logic [1:0]            i_awburst,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wlast,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic [1:0]            o_bresp,
    output logic                  o_bvalid,
    input  logic                  i_bready,
    input  logic [ADDR_W-1:0]     i_araddr,
    input  logic [7:0]            i_arlen,
    input  logic [1:0]            i_arburst,
    input  logic                  i_arvalid,
    output logic                  o_arready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_rresp,
    output logic                  o_rlast,
    output logic                  o_rvalid,
    input  logic                  i_rready
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned SIZE_LG = $clog2(BYTES);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned WORD_W  = ADDR_W - SIZE_LG;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic              last_rd_q, last_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        burst_q, burst_d;
    logic              bad_q, bad_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              sel_wr;
    logic [ADDR_W-1:0] gen_addr, next_addr;
    logic [7:0]        gen_len;
    logic [1:0]        gen_burst;
    logic              legal;
    logic [ADDR_W-1:0] beat_addr;
    logic [WORD_W-1:0] beat_word;
    logic [IDX_W-1:0]  beat_idx;
    logic              in_range;
    logic [DATA_W-1:0] beat_rdata;
    logic              mem_we;

    // Round-robin: on contention serve the channel not served last.
    always_comb begin
        sel_wr    = i_awvalid && (!i_arvalid || last_rd_q);
        o_awready = (state_q == ST_IDLE) && sel_wr;
        o_arready = (state_q == ST_IDLE) && i_arvalid && !sel_wr;
    end

    // One shared generator: fed by the request being accepted in IDLE, else the active burst.
    always_comb begin
        if (state_q == ST_IDLE) begin
            gen_addr  = sel_wr ? i_awaddr  : i_araddr;
            gen_len   = sel_wr ? i_awlen   : i_arlen;
            gen_burst = sel_wr ? i_awburst : i_arburst;
        end else begin
            gen_addr  = addr_q;
            gen_len   = len_q;
            gen_burst = burst_q;
        end
    end

    sram_axi4_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_addr_gen (
        .i_addr      (gen_addr),
        .i_len       (gen_len),
        .i_burst     (gen_burst),
        .o_next_addr (next_addr),
        .o_legal     (legal)
    );

    // Address of the beat being written, or of the read beat fetched for the next R cycle.
    always_comb begin
        if (state_q == ST_IDLE) begin
            beat_addr = i_araddr;
        end else if (state_q == ST_READ) begin
            beat_addr = next_addr;
        end else begin
            beat_addr = addr_q;
        end
        beat_word  = beat_addr[ADDR_W-1:SIZE_LG];
        in_range   = 32'(beat_word) < DEPTH;
        beat_idx   = IDX_W'(beat_word);
        beat_rdata = in_range ? mem[beat_idx] : '0;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        bad_d     = bad_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (o_awready) begin
                    addr_d    = i_awaddr;
                    len_d     = i_awlen;
                    burst_d   = i_awburst;
                    cnt_d     = 8'd0;
                    bad_d     = !legal;
                    err_d     = !legal;
                    last_rd_d = 1'b0;
                    state_d   = ST_WRITE;
                end else if (o_arready) begin
                    addr_d    = i_araddr;
                    len_d     = i_arlen;
                    burst_d   = i_arburst;
                    cnt_d     = 8'd0;
                    bad_d     = !legal;
                    last_rd_d = 1'b1;
                    rvalid_d  = 1'b1;
                    rlast_d   = (i_arlen == 8'd0);
                    rdata_d   = (legal && in_range) ? beat_rdata : '0;
                    rresp_d   = (legal && in_range) ? RESP_OKAY : RESP_SLVERR;
                    state_d   = ST_READ;
                end
            end
            ST_WRITE: begin
                if (i_wvalid) begin
                    mem_we = !bad_q && in_range;
                    if (!in_range || (i_wlast != (cnt_q == len_q))) begin
                        err_d = 1'b1;
                    end
                    addr_d = next_addr;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (i_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (i_rready) begin
                    if (cnt_q == len_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rresp_d  = RESP_OKAY;
                        rdata_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 8'd1;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                        rdata_d = (!bad_q && in_range) ? beat_rdata : '0;
                        rresp_d = (!bad_q && in_range) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and R-channel registers.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            addr_q    <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            burst_q   <= 2'b00;
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Byte-strobed SRAM write; contents are deliberately not reset.
    always_ff @(posedge i_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (i_wstrb[b]) begin
                    mem[beat_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Outputs decoded from state and registered R payload.
    always_comb begin
        o_wready = (state_q == ST_WRITE);
        o_bvalid = (state_q == ST_WRESP);
        o_bresp  = ((state_q == ST_WRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
        o_rvalid = rvalid_q;
        o_rlast  = rlast_q;
        o_rresp  = rresp_q;
        o_rdata  = rdata_q;
    end

endmodule

// File: tb/tb_sram_axi4_param.sv
// Directed bench for sram_axi4_param with a byte-level memory model and scoreboards.
module tb_sram_axi4_param;

    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [1:0]    awburst, arburst;
    logic          awvalid, arvalid, wvalid, wlast, bready, rready;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic          awready, arready, wready, bvalid, rvalid, rlast;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    sram_axi4_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .i_aclk(clk), .i_areset(rst),
        .i_awaddr(awaddr), .i_awlen(awlen), .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
        .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arlen(arlen), .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
        .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready)
    );

    int passed = 0;
    int total  = 0;
    int cycle  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL timeout %s: handshake never seen, expected within bound", name);
    endtask

    always @(posedge clk) cycle++;

    // Model: word array plus spec-level beat-address arithmetic.
    logic [DW-1:0] mmem [DEPTH];

    function automatic int beat_addr(input int start, input int len, input logic [1:0] burst, input int i);
        int span, base, a;
        case (burst)
            2'b00: a = start;
            2'b10: begin
                span = (len + 1) * 8;
                base = (start / span) * span;
                a = base + ((start - base) + i * 8) % span;
            end
            default: a = start + i * 8;
        endcase
        return a % 4096;
    endfunction

    function automatic bit burst_ok(input int len, input logic [1:0] burst);
        return (burst == 2'b00) || (burst == 2'b01) ||
               ((burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } rbeat_t;

    rbeat_t        rexp_q[$];
    logic [1:0]    bexp_q[$];
    logic [DW-1:0] rcap [16];
    logic [1:0]    rrcap [16];
    logic          rlcap [16];
    int            r_seen = 0, b_seen = 0, rbase = 0;
    logic [1:0]    bcap;
    bit            stall_prev = 0;
    logic [67:0]   stall_val;
    logic [DW-1:0] wbuf [16];
    logic [7:0]    sbuf [16];
    int            aw_cyc, ar_cyc;

    // Compare process: every R/B handshake against the scoreboards, plus R stability under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) check("r_stable", {rdata, rresp, rlast, rvalid}, stall_val);
            if (rvalid && rready) begin
                if (rexp_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    rbeat_t e;
                    e = rexp_q.pop_front();
                    check("r_beat", {rdata, rresp, rlast}, {e.data, e.resp, e.last});
                end
                rcap[(r_seen - rbase) & 15]  = rdata;
                rrcap[(r_seen - rbase) & 15] = rresp;
                rlcap[(r_seen - rbase) & 15] = rlast;
                r_seen++;
            end
            stall_prev = rvalid && !rready;
            stall_val  = {rdata, rresp, rlast, rvalid};
            if (bvalid && bready) begin
                if (bexp_q.size() == 0) check("b_unexpected", 1, 0);
                else check("b_resp", bresp, bexp_q.pop_front());
                bcap = bresp;
                b_seen++;
            end
        end
    end

    task automatic do_write(input int addr, input int len, input logic [1:0] burst,
                            input int early_last, input int abort_after);
        bit hs;
        bit err;
        int cyc, a, b0;
        err = !burst_ok(len, burst);
        awaddr = AW'(addr); awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge clk); hs = awready; @(posedge clk); #1; cyc++;
        end
        awvalid = 1'b0;
        if (!hs) begin timeout_fail("aw"); return; end
        aw_cyc = cycle;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_after) begin
                rst = 1'b1; wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            wdata = wbuf[i]; wstrb = sbuf[i];
            wlast = (early_last >= 0) ? (i == early_last) : (i == len);
            wvalid = 1'b1;
            hs = 0; cyc = 0;
            while (!hs && cyc < 50) begin
                @(negedge clk); hs = wready; @(posedge clk); #1; cyc++;
            end
            if (!hs) begin timeout_fail("w"); wvalid = 1'b0; return; end
            a = beat_addr(addr, len, burst, i);
            if (wlast != (i == len)) err = 1;
            if (a / 8 >= DEPTH) err = 1;
            else if (burst_ok(len, burst))
                for (int b = 0; b < 8; b++)
                    if (sbuf[i][b]) mmem[a / 8][b*8 +: 8] = wbuf[i][b*8 +: 8];
            if (i == len) bexp_q.push_back(err ? 2'b10 : 2'b00);
        end
        wvalid = 1'b0; wlast = 1'b0;
        b0 = b_seen; cyc = 0;
        while (b_seen == b0 - 1 + 0 && 0) cyc++;
        while (b_seen < b0 + 1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        if (b_seen < b0 + 1 && bexp_q.size() != 0) timeout_fail("b");
    endtask

    task automatic do_read(input int addr, input int len, input logic [1:0] burst,
                           input int stall_at, input int stall_n);
        bit hs, stalled;
        int cyc, a;
        rbeat_t e;
        araddr = AW'(addr); arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge clk); hs = arready; @(posedge clk); #1; cyc++;
        end
        arvalid = 1'b0;
        if (!hs) begin timeout_fail("ar"); return; end
        ar_cyc = cycle;
        rbase = r_seen;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            e.last = (i == len);
            if (!burst_ok(len, burst) || a / 8 >= DEPTH) begin
                e.data = '0; e.resp = 2'b10;
            end else begin
                e.data = mmem[a / 8]; e.resp = 2'b00;
            end
            rexp_q.push_back(e);
        end
        stalled = 0; cyc = 0;
        while (r_seen - rbase <= len && cyc < 200) begin
            if (stall_at >= 0 && !stalled && (r_seen - rbase) == stall_at) begin
                rready = 1'b0;
                repeat (stall_n) @(posedge clk);
                #1; rready = 1'b1; stalled = 1;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        if (r_seen - rbase <= len) timeout_fail("r");
    endtask

    task automatic fill(input logic [DW-1:0] base, input logic [DW-1:0] step, input logic [7:0] s);
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = base + DW'(i) * step;
            sbuf[i] = s;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int nl;
        rst = 1'b1;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 0;
        araddr = '0; arlen = '0; arburst = '0; arvalid = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 1; rready = 1;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        @(negedge clk);
        check("reset_outputs", {awready, arready, wready, bvalid, bresp, rvalid, rresp, rlast, rdata}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // INCR write/read, rlast only on final beat
        fill(64'h0, 64'h1111_1111_1111_1111, 8'hFF);
        do_write(12'h000, 7, 2'b01, -1, -1);
        check("incr_bresp", bcap, 2'b00);
        do_read(12'h000, 7, 2'b01, -1, 0);
        check("incr_beat5", rcap[5], 64'h5555_5555_5555_5555);
        nl = 0;
        for (int i = 0; i < 8; i++) nl += int'(rlcap[i]);
        check("rlast_count", nl, 1);
        check("rlast_beat8", rlcap[7], 1);

        // Partial strobe merge
        fill(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF);
        do_write(12'h040, 0, 2'b01, -1, -1);
        fill(64'hAABB_CCDD_EEFF_0011, 64'h0, 8'h0F);
        do_write(12'h040, 0, 2'b01, -1, -1);
        do_read(12'h040, 0, 2'b01, -1, 0);
        check("strb_merge", rcap[0], 64'hFFFF_FFFF_EEFF_0011);
        check("model_strb", mmem[8], 64'hFFFF_FFFF_EEFF_0011);

        // WRAP len 3 from 0x018: A->w3, B->w0, C->w1, D->w2
        wbuf[0] = 64'hA; wbuf[1] = 64'hB; wbuf[2] = 64'hC; wbuf[3] = 64'hD;
        for (int i = 0; i < 4; i++) sbuf[i] = 8'hFF;
        do_write(12'h018, 3, 2'b10, -1, -1);
        do_read(12'h000, 3, 2'b01, -1, 0);
        check("wrap_order", {rcap[0], rcap[1], rcap[2], rcap[3]}, {64'hB, 64'hC, 64'hD, 64'hA});
        fill(64'hDEAD_0000, 64'h1, 8'hFF);
        do_write(12'h000, 2, 2'b10, -1, -1);
        check("wrap_len2_bresp", bcap, 2'b10);
        do_read(12'h000, 3, 2'b01, -1, 0);
        check("wrap_len2_unchanged", {rcap[0], rcap[3]}, {64'hB, 64'hA});
        fill(64'h1234, 64'h1, 8'hFF);
        do_write(12'h000, 0, 2'b11, -1, -1);
        check("rsvd_bresp", bcap, 2'b10);

        // Out-of-range second beat, early wlast
        fill(64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF);
        do_write(12'h7F8, 0, 2'b01, -1, -1);
        do_read(12'h7F8, 1, 2'b01, -1, 0);
        check("oor_beat1", {rcap[0], rrcap[0]}, {64'h0123_4567_89AB_CDEF, 2'b00});
        check("oor_beat2", {rcap[1], rrcap[1], rlcap[1]}, {64'h0, 2'b10, 1'b1});
        fill(64'h5000, 64'h1, 8'hFF);
        do_write(12'h100, 3, 2'b01, 1, -1);
        check("early_wlast_bresp", bcap, 2'b10);
        do_read(12'h100, 3, 2'b01, -1, 0);
        do_read(12'h200, 1, 2'b11, -1, 0);
        check("rsvd_read", {rcap[0], rrcap[0]}, {64'h0, 2'b10});

        // Contention after reset: write wins, then read
        do_reset();
        fill(64'h7700, 64'h1, 8'hFF);
        fork
            do_write(12'h280, 1, 2'b01, -1, -1);
            do_read(12'h000, 3, 2'b01, -1, 0);
        join
        check("rr_write_first", aw_cyc < ar_cyc, 1);
        do_write(12'h290, 0, 2'b00, -1, -1);
        fork
            do_write(12'h2A0, 0, 2'b01, -1, -1);
            do_read(12'h280, 1, 2'b01, -1, 0);
        join
        check("rr_read_after_write", ar_cyc < aw_cyc, 1);

        // R backpressure mid-burst
        do_read(12'h000, 7, 2'b01, 3, 3);

        // Reset mid-write: committed beats stay
        fill(64'h3300, 64'h1, 8'hFF);
        do_write(12'h300, 7, 2'b01, -1, -1);
        fill(64'h9900, 64'h1, 8'hFF);
        do_write(12'h300, 7, 2'b01, -1, 3);
        @(negedge clk);
        check("reset_mid_write", {awready, arready, wready, bvalid, bresp, rvalid, rresp, rlast, rdata}, 0);
        @(posedge clk); #1 rst = 1'b0;
        do_read(12'h300, 3, 2'b01, -1, 0);
        check("partial_commit", {rcap[2], rcap[3]}, {64'h9902, 64'h3303});

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
